// File: rtl/cpu_pkg.sv
// Shared CPU constants: ALU control encodings (also used by the decoder)
// and the multiply/divide sequencer state encoding.
package cpu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_MUL = 2'b10;
  localparam logic [1:0] ALU_DIV = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } mdState_t;

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage operand/control bundle into the mul/div unit and its
// result, flag, done and stall returns.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             StartE;
  logic [1:0]       ALUControlE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic             FlushE;
  logic [WIDTH-1:0] MulDivResultE;
  logic [3:0]       MulDivFlagsE;
  logic             MulDivDoneE;
  logic             MulDivStallE;

  modport master (
    output StartE, ALUControlE, SrcAE, SrcBE, FlushE,
    input  MulDivResultE, MulDivFlagsE, MulDivDoneE, MulDivStallE
  );

  modport slave (
    input  StartE, ALUControlE, SrcAE, SrcBE, FlushE,
    output MulDivResultE, MulDivFlagsE, MulDivDoneE, MulDivStallE
  );
endinterface

// File: rtl/muldiv_core.sv
// Shared shift datapath: shift-add multiply or restoring divide, one bit per step.
// stepResult is the value the current step produces, so the caller can capture it on the last edge.
module muldiv_core #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             loadDiv,
  input  logic             step,
  input  logic             clear,
  input  logic             isDiv,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic [WIDTH-1:0] stepResult,
  output logic             lastStep
);

  logic [2*WIDTH-1:0] acc, accNext;
  logic [2*WIDTH-1:0] opB, opBNext;
  logic [WIDTH-1:0]   opA, opANext;
  logic [CNTW-1:0]    cnt;
  logic [WIDTH:0]     shifted, diff, remNext;
  logic               ge;

  // Divide: opA shifts the dividend out at the top while quotient bits enter at the bottom.
  assign shifted = {acc[WIDTH-1:0], opA[WIDTH-1]};
  assign diff    = shifted - {1'b0, opB[WIDTH-1:0]};
  assign ge      = ~diff[WIDTH];
  assign remNext = ge ? diff : shifted;

  always_comb begin
    accNext = acc;
    opANext = opA;
    opBNext = opB;
    if (isDiv) begin
      accNext = {{(WIDTH-1){1'b0}}, remNext};
      opANext = {opA[WIDTH-2:0], ge};
    end else begin
      if (opA[0]) accNext = acc + opB;
      opANext = opA >> 1;
      opBNext = opB << 1;
    end
  end

  assign stepResult = isDiv ? opANext : accNext[WIDTH-1:0];
  assign lastStep   = (cnt == CNTW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      opA <= '0;
      opB <= '0;
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      acc <= '0;
      opA <= loadDiv ? srcA : srcB;
      opB <= {{WIDTH{1'b0}}, (loadDiv ? srcB : srcA)};
      cnt <= CNTW'(WIDTH);
    end else if (step) begin
      acc <= accNext;
      opA <= opANext;
      opB <= opBNext;
      cnt <= cnt - CNTW'(1);
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned MUL/DIV for Execute; done arrives WIDTH+1 cycles after accept (1 for divide-by-zero).
// Holds the pipeline via MulDivStallE from the accept cycle through the last iteration.
module muldiv_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic      clk,
  input  logic      reset,
  muldiv_if.slave   bus
);

  mdState_t         state;
  logic             accept, busy, divZero, lastStep;
  logic [WIDTH-1:0] stepResult;
  logic [WIDTH-1:0] resultQ;
  logic [3:0]       flagsQ;

  function automatic logic [3:0] flagsOf(input logic [WIDTH-1:0] r);
    return {r[WIDTH-1], (r == '0), 2'b00};
  endfunction

  assign accept  = (state == MD_IDLE) & bus.StartE & bus.ALUControlE[1] & ~bus.FlushE;
  assign busy    = (state == MD_MUL) | (state == MD_DIV);
  assign divZero = (bus.ALUControlE == ALU_DIV) & (bus.SrcBE == '0);

  muldiv_core #(.WIDTH(WIDTH), .CNTW(CNTW)) core (
    .clk        (clk),
    .reset      (reset),
    .load       (accept & ~divZero),
    .loadDiv    (bus.ALUControlE[0]),
    .step       (busy & ~bus.FlushE),
    .clear      (busy & bus.FlushE),
    .isDiv      (state == MD_DIV),
    .srcA       (bus.SrcAE),
    .srcB       (bus.SrcBE),
    .stepResult (stepResult),
    .lastStep   (lastStep)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= MD_IDLE;
      resultQ <= '0;
      flagsQ  <= 4'b0100;
    end else begin
      case (state)
        MD_IDLE: begin
          if (accept) begin
            if (divZero) begin
              state   <= MD_DONE;
              resultQ <= '1;
              flagsQ  <= flagsOf('1);
            end else begin
              state <= bus.ALUControlE[0] ? MD_DIV : MD_MUL;
            end
          end
        end
        MD_MUL, MD_DIV: begin
          if (bus.FlushE) begin
            state <= MD_IDLE;
          end else if (lastStep) begin
            state   <= MD_DONE;
            resultQ <= stepResult;
            flagsQ  <= flagsOf(stepResult);
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign bus.MulDivResultE = resultQ;
  assign bus.MulDivFlagsE  = flagsQ;
  assign bus.MulDivDoneE   = (state == MD_DONE);
  assign bus.MulDivStallE  = accept | busy;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: latency, stall window, results, flags,
// flush, async reset and ignored ADD/SUB codes.
module tb_muldiv_unit;
  import cpu_pkg::*;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  muldiv_if #(.WIDTH(WIDTH)) bus ();

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idleInputs();
    bus.StartE      = 1'b0;
    bus.ALUControlE = ALU_ADD;
    bus.SrcAE       = '0;
    bus.SrcBE       = '0;
    bus.FlushE      = 1'b0;
  endtask

  // Issues one op for a single cycle, then measures done cycle and stall length.
  task automatic runOp(input string tag, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expRes, input logic [3:0] expFlags,
                       input int expCycle);
    int stallCnt = 0;
    int doneAt = -1;
    @(posedge clk); #1;
    bus.StartE = 1'b1; bus.ALUControlE = op; bus.SrcAE = a; bus.SrcBE = b;
    @(negedge clk);
    if (bus.MulDivStallE) stallCnt++;
    @(posedge clk); #1;
    idleInputs();
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (bus.MulDivDoneE) begin
        doneAt = i;
        break;
      end
      if (bus.MulDivStallE) stallCnt++;
    end
    check({tag, "_done_cycle"}, 64'(doneAt), 64'(expCycle));
    check({tag, "_stall_cycles"}, 64'(stallCnt), 64'(expCycle));
    check({tag, "_result"}, 64'(bus.MulDivResultE), 64'(expRes));
    check({tag, "_flags"}, 64'(bus.MulDivFlagsE), 64'(expFlags));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 64'(bus.MulDivDoneE), 64'd0);
  endtask

  // Watches a window of cycles and reports any done pulse or stall.
  task automatic expectQuiet(input string tag, input int cycles);
    int sawDone = 0;
    int sawStall = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.MulDivDoneE) sawDone++;
      if (bus.MulDivStallE) sawStall++;
    end
    check({tag, "_no_done"}, 64'(sawDone), 64'd0);
    check({tag, "_no_stall"}, 64'(sawStall), 64'd0);
  endtask

  initial begin
    idleInputs();
    #12;
    check("rst_result", 64'(bus.MulDivResultE), 64'd0);
    check("rst_flags", 64'(bus.MulDivFlagsE), 64'h4);
    check("rst_done", 64'(bus.MulDivDoneE), 64'd0);
    check("rst_stall", 64'(bus.MulDivStallE), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    runOp("mul_7x6", ALU_MUL, 32'd7, 32'd6, 32'd42, 4'b0000, 33);
    runOp("mul_ovf", ALU_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 4'b1000, 33);

    // Async reset in the middle of a divide, between clock edges.
    @(posedge clk); #1;
    bus.StartE = 1'b1; bus.ALUControlE = ALU_DIV; bus.SrcAE = 32'd100; bus.SrcBE = 32'd7;
    @(posedge clk); #1;
    idleInputs();
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_mid_stall_before", 64'(bus.MulDivStallE), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_result", 64'(bus.MulDivResultE), 64'd0);
    check("rst_mid_flags", 64'(bus.MulDivFlagsE), 64'h4);
    check("rst_mid_done", 64'(bus.MulDivDoneE), 64'd0);
    check("rst_mid_stall", 64'(bus.MulDivStallE), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    runOp("mul_3x3", ALU_MUL, 32'd3, 32'd3, 32'd9, 4'b0000, 33);

    runOp("div_zero", ALU_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 4'b1000, 1);
    runOp("div_3_5", ALU_DIV, 32'd3, 32'd5, 32'd0, 4'b0100, 33);

    // ADD and SUB codes must not engage the unit.
    @(posedge clk); #1;
    bus.StartE = 1'b1; bus.ALUControlE = ALU_ADD; bus.SrcAE = 32'd9; bus.SrcBE = 32'd4;
    @(negedge clk);
    check("add_stall", 64'(bus.MulDivStallE), 64'd0);
    @(posedge clk); #1;
    bus.ALUControlE = ALU_SUB;
    @(negedge clk);
    check("sub_stall", 64'(bus.MulDivStallE), 64'd0);
    @(posedge clk); #1;
    idleInputs();
    expectQuiet("addsub", 40);
    check("addsub_result_kept", 64'(bus.MulDivResultE), 64'd0);

    runOp("div_100_7", ALU_DIV, 32'd100, 32'd7, 32'd14, 4'b0000, 33);

    // Flush at iteration 10 of a multiply: no done, previous result kept.
    @(posedge clk); #1;
    bus.StartE = 1'b1; bus.ALUControlE = ALU_MUL; bus.SrcAE = 32'd3; bus.SrcBE = 32'd5;
    @(posedge clk); #1;
    idleInputs();
    repeat (9) begin
      @(posedge clk); #1;
    end
    bus.FlushE = 1'b1;
    @(negedge clk);
    check("flush_busy_stall", 64'(bus.MulDivStallE), 64'd1);
    @(posedge clk); #1;
    bus.FlushE = 1'b0;
    expectQuiet("flush", 40);
    check("flush_result_kept", 64'(bus.MulDivResultE), 64'd14);
    check("flush_flags_kept", 64'(bus.MulDivFlagsE), 64'h0);

    // StartE together with FlushE: flush wins.
    @(posedge clk); #1;
    bus.StartE = 1'b1; bus.FlushE = 1'b1; bus.ALUControlE = ALU_MUL;
    bus.SrcAE = 32'd2; bus.SrcBE = 32'd2;
    @(negedge clk);
    check("startflush_stall", 64'(bus.MulDivStallE), 64'd0);
    @(posedge clk); #1;
    idleInputs();
    expectQuiet("startflush", 40);
    check("startflush_result_kept", 64'(bus.MulDivResultE), 64'd14);

    runOp("mul_after", ALU_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0, 4'b0100, 33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
